// File: rtl/decimal_convert_arbiter_pkg.sv
// decimal_convert_arbiter_pkg: shared FSM states and BCD constants for the converter arbiter
package decimal_convert_arbiter_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, RESP = 2'd2} state_t;
   localparam logic [15:0] DEC_MAX = 16'd9999;
   localparam logic [15:0] BCD_SAT = 16'h9999;
endpackage

// File: rtl/binary_to_decimal.sv
// binary_to_decimal: combinational 16-bit binary to 4-digit BCD, saturating at 9999
module binary_to_decimal
   import decimal_convert_arbiter_pkg::*;
(
   input  logic [15:0] binary,
   output logic [15:0] decimal,
   output logic        overflow
);
   logic [15:0] bcd;
   // 14 bits cover every non-saturated operand, so the top two bits only feed the compare
   always_comb begin
      bcd = '0;
      for (int i = 13; i >= 0; i--) begin
         for (int d = 0; d < 4; d++)
            bcd[4*d +: 4] = (bcd[4*d +: 4] > 4'd4) ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
         bcd = {bcd[14:0], binary[i]};
      end
   end
   assign overflow = binary > DEC_MAX;
   assign decimal  = overflow ? BCD_SAT : bcd;
endmodule

// File: rtl/decimal_convert_arbiter.sv
// decimal_convert_arbiter: round-robin sharing of one binary_to_decimal among NUM_REQ requesters
module decimal_convert_arbiter
   import decimal_convert_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [16*NUM_REQ-1:0] req_binary,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   rsp_valid,
   input  logic [NUM_REQ-1:0]   rsp_ready,
   output logic [15:0]          rsp_decimal,
   output logic                 rsp_overflow,
   output logic [ID_W-1:0]      rsp_id
);
   state_t          state, state_nxt;
   logic [ID_W-1:0] ptr, win, idx, id;
   logic [15:0]     opnd, dec;
   logic            found, ovf;

   binary_to_decimal u_binary_to_decimal (
      .binary   (opnd),
      .decimal  (dec),
      .overflow (ovf)
   );

   // descending scan so the lowest offset from the pointer is the last, winning, assignment
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (req_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_nxt = state == IDLE ? (found ? CONV : IDLE) :
                  state == CONV ? RESP :
                  state == RESP ? (rsp_ready[rsp_id] ? IDLE : RESP) : IDLE;
      req_ready = (state == IDLE && found) ? NUM_REQ'(1) << win : '0;
      rsp_valid = (state == RESP) ? NUM_REQ'(1) << rsp_id : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         opnd         <= '0;
         id           <= '0;
         rsp_decimal  <= '0;
         rsp_overflow <= 1'b0;
         rsp_id       <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && found) begin
            opnd <= req_binary[16*win +: 16];
            id   <= win;
            ptr  <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
         end
         if (state == CONV) begin
            rsp_decimal  <= dec;
            rsp_overflow <= ovf;
            rsp_id       <= id;
         end
      end
   end
endmodule
